// File: rtl/demux1hot_pkg.sv
// Shared types and helpers for the one-hot demux pipeline.
// Used by demux1hot_pipe and onehot_check.
package demux1hot_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  localparam int N_MAX = 32;

  function automatic logic is_onehot(
    input logic [N_MAX-1:0] vec
  );
    return $countones(vec) == 1;
  endfunction

endpackage

// File: rtl/onehot_check.sv
// Select legality check plus highest-index-wins reduction.
// legal_o is popcount==1; onehot_o keeps only the top set bit.
module onehot_check
  import demux1hot_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] vec_i,
  output logic         legal_o,
  output logic [N-1:0] onehot_o
);

  assign legal_o = is_onehot(N_MAX'(vec_i));

  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < N; i++) begin
      if (vec_i[i]) begin
        onehot_o    = '0;
        onehot_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/demux1hot_pipe.sv
// 1-to-N one-hot demux with head+skid elastic buffer.
// Define DEMUX1HOT_TRUST_SELECT_EN to skip the select legality check.
module demux1hot_pipe
  import demux1hot_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int N     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [N-1:0]     in_sel,
  output logic [N-1:0]     out_valid,
  input  logic [N-1:0]     out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             err
);

  state_e           state_q;
  logic             in_ready_q;
  logic             err_q;
  logic [N-1:0]     head_sel_q;
  logic [WIDTH-1:0] head_data_q;
  logic [N-1:0]     skid_sel_q;
  logic [WIDTH-1:0] skid_data_q;

  logic         sel_legal;
  logic [N-1:0] sel_hi;
  logic         accept;
  logic         keep;
  logic         bad;
  logic         push;
  logic         xfer;

  onehot_check #(.N(N)) u_chk (
    .vec_i   (in_sel),
    .legal_o (sel_legal),
    .onehot_o(sel_hi)
  );

  assign accept = in_valid & in_ready_q;

`ifdef DEMUX1HOT_TRUST_SELECT_EN
  assign keep = |sel_hi;
  assign bad  = 1'b0;
`else
  assign keep = sel_legal;
  assign bad  = ~sel_legal;
`endif

  assign push = accept & keep;
  // head_sel_q is zero when empty, so this also implies head valid
  assign xfer = |(head_sel_q & out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      err_q       <= 1'b0;
      head_sel_q  <= '0;
      head_data_q <= '0;
      skid_sel_q  <= '0;
      skid_data_q <= '0;
    end else begin
      err_q <= accept & bad;
      unique case (state_q)
        EMPTY: begin
          if (push) begin
            head_sel_q  <= sel_hi;
            head_data_q <= in_data;
            state_q     <= ONE;
          end
        end
        ONE: begin
          if (xfer) begin
            if (push) begin
              head_sel_q  <= sel_hi;
              head_data_q <= in_data;
            end else begin
              head_sel_q <= '0;
              state_q    <= EMPTY;
            end
          end else if (push) begin
            skid_sel_q  <= sel_hi;
            skid_data_q <= in_data;
            in_ready_q  <= 1'b0;
            state_q     <= TWO;
          end
        end
        TWO: begin
          if (xfer) begin
            head_sel_q  <= skid_sel_q;
            head_data_q <= skid_data_q;
            skid_sel_q  <= '0;
            skid_data_q <= '0;
            in_ready_q  <= 1'b1;
            state_q     <= ONE;
          end
        end
        default: begin
          head_sel_q <= '0;
          skid_sel_q <= '0;
          in_ready_q <= 1'b1;
          state_q    <= EMPTY;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = head_sel_q;
  assign out_data  = head_data_q;
  assign err       = err_q;

endmodule

// File: tb/tb_demux1hot_pipe.sv
// Directed table, corner sequences and random scoreboard
// for demux1hot_pipe with N=4, WIDTH=8.
module tb_demux1hot_pipe;

  localparam int W = 8;
  localparam int N = 4;
`ifdef DEMUX1HOT_TRUST_SELECT_EN
  localparam bit TRUST = 1'b1;
`else
  localparam bit TRUST = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic [N-1:0] in_sel = '0;
  logic [N-1:0] out_valid;
  logic [N-1:0] out_ready = '0;
  logic [W-1:0] out_data;
  logic         err;

  int compared = 0;
  int mismatched = 0;

  demux1hot_pipe #(.WIDTH(W), .N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         v;
    logic [N-1:0] sel;
    logic [W-1:0] d;
    logic [N-1:0] rdy;
    logic [N-1:0] ov;
    logic [W-1:0] od;
    logic         ir;
    logic         er;
  } vec_t;

  typedef struct {
    logic [N-1:0] s;
    logic [W-1:0] d;
  } ent_t;

  vec_t tbl[20];
  ent_t q[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [N-1:0] s,
                       input logic [W-1:0] d, input logic [N-1:0] r);
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] top_bit(input logic [N-1:0] s);
    top_bit = '0;
    for (int i = 0; i < N; i++)
      if (s[i]) top_bit = N'(1 << i);
  endfunction

  initial begin
    logic         acc, xf, keep, bad, err_exp;
    logic [N-1:0] ks;
    ent_t         e;

    tbl[0]  = '{1'b1, 4'b0100, 8'hA5, 4'hF, 4'b0100, 8'hA5, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 4'b0001, 8'h11, 4'hF, 4'b0001, 8'h11, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 4'b0010, 8'h22, 4'hF, 4'b0010, 8'h22, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 4'b1000, 8'h33, 4'hF, 4'b1000, 8'h33, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 4'b0000, 8'h00, 4'hF, 4'b0000, 8'h33, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 4'b0100, 8'h44, 4'hF, 4'b0100, 8'h44, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 4'b0001, 8'h55, 4'hB, 4'b0100, 8'h44, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 4'b0010, 8'h66, 4'hB, 4'b0100, 8'h44, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 4'b0010, 8'h66, 4'hF, 4'b0001, 8'h55, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 4'b0010, 8'h66, 4'hE, 4'b0001, 8'h55, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 4'b0000, 8'h00, 4'hF, 4'b0010, 8'h66, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 4'b0000, 8'h00, 4'hF, 4'b0000, 8'h66, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 4'b0100, 8'h77, 4'h0, 4'b0100, 8'h77, 1'b1, 1'b0};
    tbl[13] = '{1'b1, 4'b0110, 8'h88, 4'h0, 4'b0100, 8'h77,
                TRUST ? 1'b0 : 1'b1, TRUST ? 1'b0 : 1'b1};
    tbl[14] = '{1'b1, 4'b0000, 8'h99, 4'h0, 4'b0100, 8'h77,
                TRUST ? 1'b0 : 1'b1, TRUST ? 1'b0 : 1'b1};
    tbl[15] = '{1'b0, 4'b0000, 8'h00, 4'b0100,
                TRUST ? 4'b0100 : 4'b0000, TRUST ? 8'h88 : 8'h77,
                1'b1, 1'b0};
    tbl[16] = '{1'b0, 4'b0000, 8'h00, 4'hF, 4'b0000,
                TRUST ? 8'h88 : 8'h77, 1'b1, 1'b0};
    tbl[17] = '{1'b1, 4'b0000, 8'h99, 4'hF, 4'b0000,
                TRUST ? 8'h88 : 8'h77, 1'b1, TRUST ? 1'b0 : 1'b1};
    tbl[18] = '{1'b1, 4'b1010, 8'hBB, 4'hF,
                TRUST ? 4'b1000 : 4'b0000, TRUST ? 8'hBB : 8'h77,
                1'b1, TRUST ? 1'b0 : 1'b1};
    tbl[19] = '{1'b0, 4'b0000, 8'h00, 4'hF, 4'b0000,
                TRUST ? 8'hBB : 8'h77, 1'b1, 1'b0};

    // reset state
    #12;
    chk("rst_ov", 32'(out_valid), 32'h0);
    chk("rst_od", 32'(out_data), 32'h0);
    chk("rst_ir", 32'(in_ready), 32'h1);
    chk("rst_err", 32'(err), 32'h0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].v, tbl[i].sel, tbl[i].d, tbl[i].rdy);
      step();
      chk($sformatf("tbl%0d_ov", i), 32'(out_valid), 32'(tbl[i].ov));
      chk($sformatf("tbl%0d_od", i), 32'(out_data), 32'(tbl[i].od));
      chk($sformatf("tbl%0d_ir", i), 32'(in_ready), 32'(tbl[i].ir));
      chk($sformatf("tbl%0d_err", i), 32'(err), 32'(tbl[i].er));
    end

    // fill to TWO, then async reset mid-cycle
    drive(1'b1, 4'b0001, 8'h01, 4'h0);
    step();
    drive(1'b1, 4'b0010, 8'h02, 4'h0);
    step();
    chk("two_ir", 32'(in_ready), 32'h0);
    chk("two_ov", 32'(out_valid), 32'h1);
    drive(1'b0, 4'b0000, 8'h00, 4'hF);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ov", 32'(out_valid), 32'h0);
    chk("arst_ir", 32'(in_ready), 32'h1);
    chk("arst_od", 32'(out_data), 32'h0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_ov", 32'(out_valid), 32'h0);
      chk("post_rst_ir", 32'(in_ready), 32'h1);
    end

    // 10 back-to-back beats, rotating select
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, N'(1 << (i % 4)), 8'(8'h10 + i), 4'hF);
      step();
      chk("strm_ov", 32'(out_valid), 32'(1 << (i % 4)));
      chk("strm_od", 32'(out_data), 32'(8'h10 + i));
      chk("strm_ir", 32'(in_ready), 32'h1);
    end
    drive(1'b0, 4'b0000, 8'h00, 4'hF);
    step();
    chk("strm_drain", 32'(out_valid), 32'h0);

    // random traffic against a FIFO scoreboard
    err_exp = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      logic [N-1:0] s;
      if ($urandom_range(0, 9) < 8) s = N'(1 << $urandom_range(0, N-1));
      else s = N'($urandom_range(0, 15));
      drive(($urandom_range(0, 9) < 7), s, 8'($urandom),
            N'($urandom_range(0, 15)));
      chk("rnd_ir", 32'(in_ready), 32'(q.size() < 2));
      chk("rnd_err", 32'(err), 32'(err_exp));
      chk("rnd_onehot", 32'($countones(out_valid) <= 1), 32'h1);
      if (q.size() > 0) begin
        chk("rnd_ov", 32'(out_valid), 32'(q[0].s));
        chk("rnd_od", 32'(out_data), 32'(q[0].d));
      end else begin
        chk("rnd_ov", 32'(out_valid), 32'h0);
      end
      acc = in_valid && (q.size() < 2);
      xf  = (q.size() > 0) && ((q[0].s & out_ready) != '0);
      if (TRUST) begin
        ks   = top_bit(in_sel);
        keep = (in_sel != '0);
        bad  = 1'b0;
      end else begin
        ks   = in_sel;
        keep = ($countones(in_sel) == 1);
        bad  = !keep;
      end
      if (xf) void'(q.pop_front());
      if (acc && keep) begin
        e.s = ks;
        e.d = in_data;
        q.push_back(e);
      end
      err_exp = acc && bad;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
